lfsr_note_gen: RTL

Parametrised successor to the fixed 16-bit rhythm LFSR. It provides a configurable Fibonacci LFSR with run-time seed load and all-zero lockup protection. It also includes a handshaked note generator: on each beat tick it draws a lane pattern and a density-gated spawn decision, then holds the note until the note-lane consumer accepts it. It sits between the beat timer and the note-lane scroll logic.

---
 rtl/lfsr_note_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/lfsr_note_gen.sv
// Configurable Fibonacci LFSR with seed load and lockup protection, plus a
// handshaked note generator that turns beat ticks into density-gated lane patterns.
module lfsr_note_gen #(
  parameter int unsigned           WIDTH     = 16,
  parameter logic [WIDTH-1:0]      TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0]      SEED      = 16'h1234,
  parameter int unsigned           N_LANES   = 4,
  parameter int unsigned           PROB_BITS = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_En,
  input  logic                 i_Seed_Load,
  input  logic [WIDTH-1:0]     i_Seed,
  input  logic                 i_Tick,
  input  logic [PROB_BITS-1:0] i_Density,
  input  logic                 i_Note_Ready,
  output logic [WIDTH-1:0]     o_Rand,
  output logic                 o_Note_Valid,
  output logic [N_LANES-1:0]   o_Note_Lanes,
  output logic                 o_Drop,
  output logic                 o_Lockup
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [N_LANES-1:0]   lanes_q, lanes_d;
  logic                 drop_q, drop_d;
  logic                 lockup_q, lockup_d;

  logic                 fb;
  logic [N_LANES-1:0]   lanes_raw, lanes_new;
  logic [PROB_BITS-1:0] prob;
  logic                 spawn;

  // Spawn fields come from the pre-update state, regardless of load/step.
  assign fb        = ^(r_q & TAPS);
  assign lanes_raw = r_q[WIDTH-1 -: N_LANES];
  assign lanes_new = (lanes_raw == '0) ? N_LANES'(1) : lanes_raw;
  assign prob      = r_q[PROB_BITS-1:0];
  assign spawn     = i_Tick && (prob < i_Density);

  always_comb begin
    r_d      = r_q;
    lockup_d = 1'b0;
    if (i_Seed_Load) begin
      r_d      = (i_Seed == '0) ? SEED : i_Seed;
      lockup_d = (i_Seed == '0);
    end else if (i_En) begin
      r_d = {r_q[WIDTH-2:0], fb};
    end
  end

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    drop_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (spawn) begin
          state_d = StHold;
          lanes_d = lanes_new;
        end
      end
      StHold: begin
        if (i_Note_Ready) begin
          // Back-to-back accept and spawn keeps valid high with no bubble.
          if (spawn) begin
            lanes_d = lanes_new;
          end else begin
            state_d = StIdle;
            lanes_d = '0;
          end
        end else if (i_Tick) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        lanes_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q  <= StIdle;
      r_q      <= SEED;
      lanes_q  <= '0;
      drop_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      lanes_q  <= lanes_d;
      drop_q   <= drop_d;
      lockup_q <= lockup_d;
    end
  end

  assign o_Rand       = r_q;
  assign o_Note_Valid = (state_q == StHold);
  assign o_Note_Lanes = lanes_q;
  assign o_Drop       = drop_q;
  assign o_Lockup     = lockup_q;

endmodule
